wishbone_to_axi4_simple: RTL

//  Wishbone classic slave to AXI4 master bridge; one transaction outstanding, single beat.

---
 rtl/wb_axi_bridge_pkg.sv | 24 ++
 rtl/wishbone_to_axi4_simple.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_axi_bridge_pkg.sv
// Package: wb_axi_bridge_pkg
// Shared FSM state encoding and AXI response codes for the Wishbone-to-AXI4 bridge.
package wb_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    ACK
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // SLVERR and DECERR are the two failing AXI responses.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/wishbone_to_axi4_simple.sv
// Module: wishbone_to_axi4_simple
// Wishbone classic slave to AXI4 master bridge, single beat, one transaction in flight.
// Each Wishbone cycle becomes one AXI write (AW+W then B) or one AXI read (AR then R).
// Optional macro WB2AXI_ERR_EN adds the WB_ERR port: SLVERR/DECERR responses then
// pulse WB_ERR instead of WB_ACK. Without it every response ends in WB_ACK.
module wishbone_to_axi4_simple
  import wb_axi_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    WB_CYC,
  input  logic                    WB_STB,
  input  logic                    WB_WE,
  input  logic [ADDR_WIDTH-1:0]   WB_ADDR,
  input  logic [DATA_WIDTH-1:0]   WB_WDATA,
  input  logic [DATA_WIDTH/8-1:0] WB_SEL,
  output logic [DATA_WIDTH-1:0]   WB_RDATA,
  output logic                    WB_ACK,
`ifdef WB2AXI_ERR_EN
  output logic                    WB_ERR,
`endif
  output logic [ID_WIDTH-1:0]     AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [ID_WIDTH-1:0]     AXI_BID,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [ID_WIDTH-1:0]     AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]     AXI_RID,
  input  logic [DATA_WIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic                    aw_valid_q;
  logic                    w_valid_q;
  logic                    b_ready_q;
  logic                    ar_valid_q;
  logic                    r_ready_q;
  logic                    ack_q;
  logic                    abort_q;
  logic                    ack_busy;
  logic                    take_req;
  logic                    aw_ok;
  logic                    w_ok;
  logic                    unused_ids;

`ifdef WB2AXI_ERR_EN
  logic                    err_q;
  logic [1:0]              resp_q;
  assign WB_ERR   = err_q;
  assign ack_busy = ack_q | err_q;
`else
  logic                    unused_resp;
  assign unused_resp = ^{AXI_BRESP, AXI_RRESP};
  assign ack_busy    = ack_q;
`endif

  // Only one transaction is ever in flight, so the response IDs carry no information.
  assign unused_ids = ^{AXI_BID, AXI_RID};

  assign WB_RDATA    = rdata_q;
  assign WB_ACK      = ack_q;
  assign AXI_AWID    = ID_WIDTH'(AXI_ID);
  assign AXI_ARID    = ID_WIDTH'(AXI_ID);
  assign AXI_AWADDR  = addr_q;
  assign AXI_ARADDR  = addr_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WSTRB   = sel_q;
  assign AXI_AWVALID = aw_valid_q;
  assign AXI_WVALID  = w_valid_q;
  assign AXI_BREADY  = b_ready_q;
  assign AXI_ARVALID = ar_valid_q;
  assign AXI_RREADY  = r_ready_q;

  // A request is refused while the previous acknowledge is still on the bus, so a master
  // that drops STB one cycle after ACK is not seen as issuing a second request.
  assign take_req = WB_CYC & WB_STB & ~ack_busy;
  // A write channel is finished once its VALID has dropped or is handshaking right now.
  assign aw_ok    = ~aw_valid_q | AXI_AWREADY;
  assign w_ok     = ~w_valid_q  | AXI_WREADY;

  // Next-state decode for the transaction sequencer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:         if (take_req) next_state = WB_WE ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (aw_ok && w_ok) next_state = WR_RESP;
      WR_RESP:      if (AXI_BVALID) next_state = ACK;
      RD_ADDR:      if (AXI_ARREADY) next_state = RD_DATA;
      RD_DATA:      if (AXI_RVALID) next_state = ACK;
      ACK:          next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // State register plus all registered bus outputs; an abandoned Wishbone cycle lets
  // the AXI side finish but suppresses the final acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      rdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      ack_q      <= 1'b0;
      abort_q    <= 1'b0;
`ifdef WB2AXI_ERR_EN
      err_q      <= 1'b0;
      resp_q     <= AXI_RESP_OKAY;
`endif
    end else begin
      state <= next_state;
      ack_q <= 1'b0;
`ifdef WB2AXI_ERR_EN
      err_q <= 1'b0;
`endif
      if ((state != IDLE) && !WB_CYC) abort_q <= 1'b1;
      case (state)
        IDLE: begin
          if (take_req) begin
            addr_q  <= WB_ADDR;
            wdata_q <= WB_WDATA;
            sel_q   <= WB_SEL;
            abort_q <= 1'b0;
            if (WB_WE) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (AXI_AWREADY) aw_valid_q <= 1'b0;
          if (AXI_WREADY) w_valid_q <= 1'b0;
          if (aw_ok && w_ok) b_ready_q <= 1'b1;
        end
        WR_RESP: begin
          if (AXI_BVALID) begin
            b_ready_q <= 1'b0;
`ifdef WB2AXI_ERR_EN
            resp_q    <= AXI_BRESP;
`endif
          end
        end
        RD_ADDR: begin
          if (AXI_ARREADY) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (AXI_RVALID) begin
            r_ready_q <= 1'b0;
            rdata_q   <= AXI_RDATA;
`ifdef WB2AXI_ERR_EN
            resp_q    <= AXI_RRESP;
`endif
          end
        end
        ACK: begin
          if (WB_CYC && !abort_q) begin
`ifdef WB2AXI_ERR_EN
            ack_q <= ~is_err_resp(resp_q);
            err_q <= is_err_resp(resp_q);
`else
            ack_q <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
